// File: rtl/axis_fifo_loopback.sv
// AXI-Stream loopback buffer: DEPTH-entry first-word fall-through FIFO carrying {last, data},
// with optional byte reversal on the write side and a delivered-packet counter.
module axis_fifo_loopback #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned BYTE_SWAP  = 0
) (
  input  logic                          axi_clk,
  input  logic                          axi_reset,
  input  logic                          s_axis_valid,
  input  logic [DATA_WIDTH-1:0]         s_axis_data,
  input  logic                          s_axis_last,
  output logic                          s_axis_ready,
  output logic                          m_axis_valid,
  output logic [DATA_WIDTH-1:0]         m_axis_data,
  output logic                          m_axis_last,
  input  logic                          m_axis_ready,
  output logic [$clog2(DEPTH+1)-1:0]    fill_count,
  output logic [15:0]                   pkt_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned NB = DATA_WIDTH / 8;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [DATA_WIDTH:0]   r_mem [DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_fill;
  logic [15:0]           r_pkt;

  logic                  w_push;
  logic                  w_pop;
  logic [DATA_WIDTH-1:0] w_swapped;
  logic [DATA_WIDTH-1:0] w_wr_data;

  // NOTE: every signal driven in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    w_swapped = '0;
    for (int i = 0; i < int'(NB); i++) begin
      w_swapped[8*i +: 8] = s_axis_data[8*(int'(NB)-1-i) +: 8];
    end
  end

  assign w_wr_data = (BYTE_SWAP != 0) ? w_swapped : s_axis_data;

  // Handshakes depend only on registered fill level (and reset), never on the far side's ready.
  assign s_axis_ready = axi_reset | (r_fill != FULL);
  assign m_axis_valid = ~axi_reset & (r_fill != '0);
  assign w_push       = s_axis_valid & ~axi_reset & (r_fill != FULL);
  assign w_pop        = m_axis_valid & m_axis_ready;

  assign {m_axis_last, m_axis_data} = r_mem[r_rd_ptr];
  assign fill_count = r_fill;
  assign pkt_count  = r_pkt;

  // NOTE: the storage array has no reset; only pointers and counters define what is valid.
  always_ff @(posedge axi_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {s_axis_last, w_wr_data};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge axi_clk) begin
    if (axi_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fill   <= '0;
      r_pkt    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_fill <= r_fill + CW'(1);
        2'b01:   r_fill <= r_fill - CW'(1);
        default: r_fill <= r_fill;
      endcase
      if (w_pop && m_axis_last) r_pkt <= r_pkt + 16'd1;
    end
  end

endmodule

// File: tb/tb_axis_fifo_loopback.sv
// Directed bench for axis_fifo_loopback: a straight-through and a byte-swapping instance
// share stimulus; expected values are hand-computed or come from a queue model.
module tb_axis_fifo_loopback;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid;
  logic [31:0] s_data;
  logic        s_last;
  logic        m_ready;

  logic        s_ready, m_valid, m_last;
  logic [31:0] m_data;
  logic [4:0]  fill;
  logic [15:0] pkt;

  logic        s_ready_sw, m_valid_sw, m_last_sw;
  logic [31:0] m_data_sw;
  logic [4:0]  fill_sw;
  logic [15:0] pkt_sw;

  int errors = 0;
  int checks = 0;

  int          sent, rcvd, cyc, lasts_rx;
  logic [32:0] q [$];
  logic [32:0] exp_word;
  logic [32:0] prev_word;
  logic        prev_stall;

  always #5 clk = ~clk;

  axis_fifo_loopback #(.DATA_WIDTH(32), .DEPTH(16), .BYTE_SWAP(0)) dut (
    .axi_clk(clk), .axi_reset(rst),
    .s_axis_valid(s_valid), .s_axis_data(s_data), .s_axis_last(s_last), .s_axis_ready(s_ready),
    .m_axis_valid(m_valid), .m_axis_data(m_data), .m_axis_last(m_last), .m_axis_ready(m_ready),
    .fill_count(fill), .pkt_count(pkt)
  );

  axis_fifo_loopback #(.DATA_WIDTH(32), .DEPTH(16), .BYTE_SWAP(1)) dut_sw (
    .axi_clk(clk), .axi_reset(rst),
    .s_axis_valid(s_valid), .s_axis_data(s_data), .s_axis_last(s_last), .s_axis_ready(s_ready_sw),
    .m_axis_valid(m_valid_sw), .m_axis_data(m_data_sw), .m_axis_last(m_last_sw), .m_axis_ready(m_ready),
    .fill_count(fill_sw), .pkt_count(pkt_sw)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b0;
    step(); step();
    check("rst_hold_m_valid", 64'(m_valid), 64'd0);
    check("rst_hold_s_ready", 64'(s_ready), 64'd1);
    rst = 1'b0;
    check("rst_fill", 64'(fill), 64'd0);
    check("rst_pkt", 64'(pkt), 64'd0);
    check("rst_m_valid", 64'(m_valid), 64'd0);
    check("rst_s_ready", 64'(s_ready), 64'd1);

    // Single-beat packet, latency 1, swap on the second instance.
    m_ready = 1'b1; s_valid = 1'b1; s_data = 32'h11223344; s_last = 1'b1;
    step();
    s_valid = 1'b0; s_last = 1'b0;
    check("lat_m_valid", 64'(m_valid), 64'd1);
    check("lat_m_data", 64'(m_data), 64'h11223344);
    check("lat_m_last", 64'(m_last), 64'd1);
    check("lat_fill", 64'(fill), 64'd1);
    check("swap_m_data", 64'(m_data_sw), 64'h44332211);
    check("swap_m_last", 64'(m_last_sw), 64'd1);
    check("swap_m_valid", 64'(m_valid_sw), 64'd1);
    step();
    check("pop_pkt", 64'(pkt), 64'd1);
    check("pop_fill", 64'(fill), 64'd0);
    check("pop_m_valid", 64'(m_valid), 64'd0);

    // Fill to full with 0..15 (last on 15), then pop while offering a push.
    m_ready = 1'b0; s_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      s_data = 32'(i); s_last = (i == 15);
      step();
    end
    s_data = 32'h99; s_last = 1'b0;
    check("full_fill", 64'(fill), 64'd16);
    check("full_s_ready", 64'(s_ready), 64'd0);
    check("full_head", 64'(m_data), 64'd0);
    m_ready = 1'b1;
    step();
    s_valid = 1'b0;
    check("full_pop_fill", 64'(fill), 64'd15);
    check("full_pop_s_ready", 64'(s_ready), 64'd1);
    for (int i = 1; i < 16; i++) begin
      check("drain_data", 64'(m_data), 64'(i));
      check("drain_last", 64'(m_last), 64'(i == 15));
      step();
    end
    check("drain_empty", 64'(m_valid), 64'd0);
    check("drain_fill", 64'(fill), 64'd0);
    check("drain_pkt", 64'(pkt), 64'd2);

    // Random valid/ready, 40 beats (two write-pointer wraps), against a queue model.
    sent = 0; rcvd = 0; cyc = 0; lasts_rx = 0; prev_stall = 1'b0; prev_word = '0;
    while (rcvd < 40 && cyc < 2000) begin
      s_valid = (sent < 40) && ($urandom_range(0, 1) == 1);
      s_data  = $urandom;
      s_last  = ($urandom_range(0, 1) == 1);
      m_ready = ($urandom_range(0, 1) == 1);
      if (prev_stall) check("stall_hold", 64'({m_last, m_data}), 64'(prev_word));
      check("rnd_fill", 64'(fill), 64'(q.size()));
      check("rnd_s_ready", 64'(s_ready), 64'(q.size() < 16));
      check("rnd_m_valid", 64'(m_valid), 64'(q.size() != 0));
      prev_stall = m_valid && !m_ready;
      prev_word  = {m_last, m_data};
      if (m_valid && m_ready) begin
        exp_word = (q.size() > 0) ? q.pop_front() : 'x;
        check("rnd_order", 64'({m_last, m_data}), 64'(exp_word));
        if (exp_word[32] === 1'b1) lasts_rx++;
        rcvd++;
      end
      if (s_valid && s_ready) begin
        q.push_back({s_last, s_data});
        sent++;
      end
      step();
      cyc++;
    end
    s_valid = 1'b0; m_ready = 1'b0;
    check("rnd_rx_count", 64'(rcvd), 64'd40);
    check("rnd_pkt", 64'(pkt), 64'(2 + lasts_rx));
    check("rnd_sw_fill", 64'(fill_sw), 64'd0);

    // Reset while holding 5 beats, with a push and pop offered in the reset cycle.
    s_valid = 1'b1; s_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s_data = 32'(8'hC0 + i);
      step();
    end
    check("pre_rst_fill", 64'(fill), 64'd5);
    rst = 1'b1; m_ready = 1'b1;
    #1;
    check("in_rst_m_valid", 64'(m_valid), 64'd0);
    check("in_rst_s_ready", 64'(s_ready), 64'd1);
    check("in_rst_s_ready_sw", 64'(s_ready_sw), 64'd1);
    step();
    rst = 1'b0; s_valid = 1'b0; m_ready = 1'b0; s_last = 1'b0;
    check("post_rst_fill", 64'(fill), 64'd0);
    check("post_rst_m_valid", 64'(m_valid), 64'd0);
    check("post_rst_s_ready", 64'(s_ready), 64'd1);
    check("post_rst_pkt", 64'(pkt), 64'd0);
    s_valid = 1'b1; s_data = 32'hA5;
    step();
    s_valid = 1'b0;
    check("a5_m_valid", 64'(m_valid), 64'd1);
    check("a5_m_data", 64'(m_data), 64'hA5);
    check("a5_swap_data", 64'(m_data_sw), 64'hA5000000);
    m_ready = 1'b1;
    step();
    check("a5_drained", 64'(fill), 64'd0);

    // 65535 single-beat packets streamed back-to-back, then one more to wrap the counter.
    s_valid = 1'b1; s_last = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      s_data = 32'(i);
      step();
    end
    s_valid = 1'b0;
    step();
    check("pkt_ffff", 64'(pkt), 64'hFFFF);
    check("pkt_ffff_fill", 64'(fill), 64'd0);
    s_valid = 1'b1; s_data = 32'h5A;
    step();
    s_valid = 1'b0;
    step();
    check("pkt_wrap", 64'(pkt), 64'h0000);
    check("pkt_wrap_sw", 64'(pkt_sw), 64'h0000);
    check("pkt_wrap_fill", 64'(fill), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axis_fifo_loopback.md
AXIS_FIFO_LOOPBACK -- requirements
Module: axis_fifo_loopback

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, stream data width in bits; legal values are multiples of 8, 8..256.
REQ-002 The block SHALL have parameter DEPTH, default 16, buffer entries; legal values are powers of 2, 2..1024.
REQ-003 The block SHALL have parameter BYTE_SWAP, default 0; 0 = pass bytes unchanged, 1 = reverse byte order.
REQ-004 The block SHALL have port axi_clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port axi_reset, input, 1 bit, reset; it is synchronous and active-high.
REQ-006 The block SHALL have port s_axis_valid, input, 1 bit, upstream beat valid.
REQ-007 The block SHALL have port s_axis_data, input, DATA_WIDTH bits, upstream beat data.
REQ-008 The block SHALL have port s_axis_last, input, 1 bit, upstream end-of-packet marker.
REQ-009 The block SHALL have port s_axis_ready, output, 1 bit, block can accept a beat.
REQ-010 The block SHALL have port m_axis_valid, output, 1 bit, downstream beat valid.
REQ-011 The block SHALL have port m_axis_data, output, DATA_WIDTH bits, downstream beat data.
REQ-012 The block SHALL have port m_axis_last, output, 1 bit, downstream end-of-packet marker.
REQ-013 The block SHALL have port m_axis_ready, input, 1 bit, downstream can accept a beat.
REQ-014 The block SHALL have port fill_count, output, clog2(DEPTH+1) bits, number of stored beats.
REQ-015 The block SHALL have port pkt_count, output, 16 bits, number of packets delivered downstream.

Function
REQ-016 The block SHALL define a push as s_axis_valid & s_axis_ready at a rising edge, and a pop as m_axis_valid & m_axis_ready at a rising edge.
REQ-017 The block SHALL store each pushed beat {last, data} in a DEPTH-entry circular buffer at the write pointer; the write pointer then advances modulo DEPTH.
REQ-018 The block SHALL drive s_axis_ready = (fill_count < DEPTH), combinationally from registered state only; s_axis_ready SHALL NOT depend on m_axis_ready.
REQ-019 The block SHALL drive m_axis_valid = (fill_count != 0); m_axis_data and m_axis_last SHALL come from the entry at the read pointer (first-word fall-through).
REQ-020 The block SHALL advance the read pointer modulo DEPTH on each pop.
REQ-021 The block SHALL have a latency of exactly 1 cycle: a beat pushed into an empty buffer at edge N is presented with m_axis_valid=1 after edge N; there is no combinational input-to-output path.
REQ-022 The block SHALL update fill_count by +1 for a push only, -1 for a pop only, and unchanged for a simultaneous push and pop.
REQ-023 When full, the block SHALL accept no push, even if a pop occurs in the same cycle; s_axis_ready rises the cycle after that pop.
REQ-024 When empty, the block SHALL perform no pop, and m_axis_data SHALL be don't-care.
REQ-025 While m_axis_valid=1 and m_axis_ready=0, the block SHALL hold m_axis_data and m_axis_last stable, and SHALL never lose, duplicate or reorder a beat.
REQ-026 With BYTE_SWAP=1, the block SHALL output byte i of m_axis_data equal to byte (DATA_WIDTH/8-1-i) of the pushed word; with BYTE_SWAP=0 the data SHALL be identical; last SHALL be unaffected in both modes.
REQ-027 The block SHALL increment pkt_count by 1 on each pop with m_axis_last=1, wrapping from 0xFFFF to 0x0000.
REQ-028 The block SHALL leave buffer contents unchanged on pointer wrap-around; only the pointers wrap.

Reset
REQ-029 On axi_reset=1 at a rising edge, the block SHALL clear the read pointer, write pointer, fill_count and pkt_count to 0.
REQ-030 During and after reset, the block SHALL drive m_axis_valid=0 and s_axis_ready=1; stored beats are discarded, including a reset applied mid-packet or while full.
REQ-031 The block SHALL NOT reset the buffer memory; m_axis_data and m_axis_last are don't-care after reset.
REQ-032 During a reset cycle, the block SHALL accept no push and perform no pop.

Verification
REQ-033 The bench SHALL cover: DEPTH=16, m_axis_ready=1, push 0x11223344 with last=1 -> after 1 cycle m_axis_data=0x11223344, m_axis_last=1; after the pop, pkt_count=1.
REQ-034 The bench SHALL cover: BYTE_SWAP=1, push 0x11223344 -> m_axis_data=0x44332211.
REQ-035 The bench SHALL cover: m_axis_ready=0, push 16 beats 0..15 -> fill_count=16, s_axis_ready=0; then one pop with s_axis_valid=1 -> no push that cycle, fill_count=15, s_axis_ready=1 the next cycle.
REQ-036 The bench SHALL cover: 40 beats with random valid/ready, at least 2 pointer wraps -> output sequence equals input sequence exactly, and data stays stable whenever stalled.
REQ-037 The bench SHALL cover: fill with 5 beats, then assert reset for 1 cycle -> fill_count=0, m_axis_valid=0, s_axis_ready=1, pkt_count=0; then push 0xA5 -> 0xA5 appears after 1 cycle.
REQ-038 The bench SHALL cover: preload pkt_count to 0xFFFF via 65535 single-beat packets, then one more packet -> pkt_count=0x0000.
